// File: rtl/tcdm_master_shim.sv
// tcdm_master_shim
//   Per-requestor front-end for one TCDM crossbar input port. A one-entry
//   request register turns the core valid/ready stream into the crossbar
//   req/gnt protocol. A credit counter bounds accepted-but-unreturned
//   transactions, and an in-order response FIFO lets the core back-pressure
//   responses without losing data.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i / req_ready_o     core request handshake
//   req_add_i, req_wen_i, req_wdata_i   core request payload
//   resp_valid_o / resp_ready_i   core response handshake
//   resp_rdata_o                  FIFO head data
//   req_o, add_o, wen_o, wdata_o  crossbar request (from the request register)
//   gnt_i                         crossbar grant
//   vld_i, rdata_i                crossbar response (one pulse per grant)
//   outstanding_o                 current credit count

module tcdm_master_shim #(
  parameter int unsigned NumOut         = 4,
  parameter int unsigned ReqDataWidth   = 32,
  parameter int unsigned RespDataWidth  = 32,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned AddrW = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrW-1:0]         req_add_i,
  input  logic                     req_wen_i,
  input  logic [ReqDataWidth-1:0]  req_wdata_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [RespDataWidth-1:0] resp_rdata_o,
  output logic                     req_o,
  output logic [AddrW-1:0]         add_o,
  output logic                     wen_o,
  output logic [ReqDataWidth-1:0]  wdata_o,
  input  logic                     gnt_i,
  input  logic                     vld_i,
  input  logic [RespDataWidth-1:0] rdata_i,
  output logic [CntW-1:0]          outstanding_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return {PtrW{1'b0}};
    end else begin
      return p + PtrW'(1);
    end
  endfunction

  logic                     req_valid_r, req_valid_n_s;
  logic [AddrW-1:0]         add_r, add_n_s;
  logic                     wen_r, wen_n_s;
  logic [ReqDataWidth-1:0]  wdata_r, wdata_n_s;
  logic [CntW-1:0]          cnt_r, cnt_n_s;
  logic [CntW-1:0]          fill_r, fill_n_s;
  logic [PtrW-1:0]          rd_ptr_r, wr_ptr_r;
  logic [RespDataWidth-1:0] mem_r [MaxOutstanding];

  logic ready_s, accept_s, grant_s, push_s, pop_s, empty_s, full_s;

  assign empty_s  = (fill_r == {CntW{1'b0}});
  assign full_s   = (fill_r == CntW'(MaxOutstanding));
  // Ready looks through a same-cycle grant so back-to-back requests stream.
  assign ready_s  = (cnt_r < CntW'(MaxOutstanding)) && (!req_valid_r || gnt_i);
  assign accept_s = req_valid_i && ready_s;
  assign grant_s  = req_valid_r && gnt_i;
  // Credits make a full-FIFO push impossible; the gate only protects storage.
  assign push_s   = vld_i && !full_s;
  assign pop_s    = !empty_s && resp_ready_i;

  assign req_ready_o   = ready_s;
  assign req_o         = req_valid_r;
  assign add_o         = add_r;
  assign wen_o         = wen_r;
  assign wdata_o       = wdata_r;
  assign resp_valid_o  = !empty_s;
  assign resp_rdata_o  = mem_r[rd_ptr_r];
  assign outstanding_o = cnt_r;

  // Request register next state: load on accept, clear valid on a bare grant.
  always_comb begin
    req_valid_n_s = req_valid_r;
    add_n_s       = add_r;
    wen_n_s       = wen_r;
    wdata_n_s     = wdata_r;
    if (accept_s) begin
      req_valid_n_s = 1'b1;
      add_n_s       = req_add_i;
      wen_n_s       = req_wen_i;
      wdata_n_s     = req_wdata_i;
    end else if (grant_s) begin
      req_valid_n_s = 1'b0;
    end else begin
      req_valid_n_s = req_valid_r;
    end
  end

  // Credit and FIFO fill counters; simultaneous inc/dec cancel.
  always_comb begin
    cnt_n_s  = cnt_r;
    fill_n_s = fill_r;
    case ({accept_s, pop_s})
      2'b10:   cnt_n_s = cnt_r + CntW'(1);
      2'b01:   cnt_n_s = cnt_r - CntW'(1);
      default: cnt_n_s = cnt_r;
    endcase
    case ({push_s, pop_s})
      2'b10:   fill_n_s = fill_r + CntW'(1);
      2'b01:   fill_n_s = fill_r - CntW'(1);
      default: fill_n_s = fill_r;
    endcase
  end

  // Request register, counters and FIFO pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_r <= 1'b0;
      add_r       <= {AddrW{1'b0}};
      wen_r       <= 1'b0;
      wdata_r     <= {ReqDataWidth{1'b0}};
      cnt_r       <= {CntW{1'b0}};
      fill_r      <= {CntW{1'b0}};
      rd_ptr_r    <= {PtrW{1'b0}};
      wr_ptr_r    <= {PtrW{1'b0}};
    end else begin
      req_valid_r <= req_valid_n_s;
      add_r       <= add_n_s;
      wen_r       <= wen_n_s;
      wdata_r     <= wdata_n_s;
      cnt_r       <= cnt_n_s;
      fill_r      <= fill_n_s;
      rd_ptr_r    <= pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      wr_ptr_r    <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    end
  end

  // Response storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        mem_r[i] <= {RespDataWidth{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= rdata_i;
    end
  end

  tcdm_master_shim_chk u_chk (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .vld       (vld_i),
    .fifo_full (full_s),
    .pop       (pop_s),
    .cnt_zero  (cnt_r == {CntW{1'b0}})
  );

endmodule

// tcdm_master_shim_chk
//   Protocol checks: a crossbar response into a full FIFO, or a core pop
//   with no credit in use, means the credit accounting has been broken.
// Ports: clk_i, rst_ni, vld, fifo_full, pop, cnt_zero (all 1 bit, inputs)
module tcdm_master_shim_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic vld,
  input logic fifo_full,
  input logic pop,
  input logic cnt_zero
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(vld && fifo_full))
    else $fatal(1, "tcdm_master_shim: response arrived while FIFO full");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && cnt_zero))
    else $fatal(1, "tcdm_master_shim: pop with zero credits in use");

endmodule

// File: tb/tb_tcdm_master_shim.sv
module tb_tcdm_master_shim;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_add_i;
  logic        req_wen_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        req_o;
  logic [1:0]  add_o;
  logic        wen_o;
  logic [31:0] wdata_o;
  logic        gnt_i, vld_i;
  logic [31:0] rdata_i;
  logic [2:0]  outstanding_o;

  tcdm_master_shim dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_add_i(req_add_i), .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rv; logic [1:0] add; logic wen; logic [31:0] wd;
    logic gnt; logic vld; logic [31:0] rd; logic rr;
    logic e_rdy; logic e_req; logic [1:0] e_add; logic e_wen; logic [31:0] e_wd;
    logic e_rv; logic [31:0] e_rdata; logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[22];
  int checks = 0;
  int failures = 0;

  // crossbar model state (RespLat = 1) and per-cycle observations
  logic        pend_vld;
  logic [31:0] pend_data, resp_cnt;
  logic        obs_acc, obs_pop;
  logic [31:0] obs_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle with the crossbar model supplying vld_i/rdata_i.
  task automatic cyc(input logic rv, input logic [1:0] add, input logic wen,
                     input logic [31:0] wd, input logic gnt, input logic rr);
    req_valid_i = rv; req_add_i = add; req_wen_i = wen; req_wdata_i = wd;
    gnt_i = gnt; resp_ready_i = rr; vld_i = pend_vld; rdata_i = pend_data;
    #1;
    obs_acc  = req_valid_i && req_ready_o;
    obs_pop  = resp_valid_o && resp_ready_i;
    obs_data = resp_rdata_o;
    if (req_o && gnt_i) begin
      pend_vld = 1'b1; pend_data = resp_cnt; resp_cnt = resp_cnt + 32'd1;
    end else begin
      pend_vld = 1'b0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    //          rv    add   wen   wd             gnt   vld   rd             rr  | rdy   req   add   wen   wd             rv    rdata          cnt
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        3'd1};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        3'd1};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 3'd1};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    vecs[5]  = '{1'b1, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        3'd0};
    for (int i = 6; i <= 10; i++) begin
      vecs[i] = '{1'b1, 2'd3, 1'b0, 32'h11111111, 1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd1};
    end
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd1};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h12345678, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd1};
    vecs[13] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b1, 32'h12345678, 3'd1};
    vecs[14] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd0};
    vecs[15] = '{1'b1, 2'd3, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        3'd0};
    vecs[16] = '{1'b1, 2'd0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0,        1'b0, 32'h0,        3'd1};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000AAAA, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0,        3'd2};
    vecs[18] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000BBBB, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0000AAAA, 3'd2};
    vecs[19] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0000AAAA, 3'd2};
    vecs[20] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b1, 32'h0000BBBB, 3'd1};
    vecs[21] = '{1'b0, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0, 32'hDEADBEEF, 3'd0};

    rst_ni = 1'b0;
    req_valid_i = 1'b0; req_add_i = 2'd0; req_wen_i = 1'b0; req_wdata_i = 32'h0;
    resp_ready_i = 1'b0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = 32'h0;
    pend_vld = 1'b0; pend_data = 32'h0; resp_cnt = 32'h0;
    obs_acc = 1'b0; obs_pop = 1'b0; obs_data = 32'h0;

    // reset state
    #12;
    chk("rst_req", {31'd0, req_o}, 32'd0);
    chk("rst_add", {30'd0, add_o}, 32'd0);
    chk("rst_wen", {31'd0, wen_o}, 32'd0);
    chk("rst_wdata", wdata_o, 32'h0);
    chk("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'h0);
    chk("rst_cnt", {29'd0, outstanding_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // table: single load, grant stall, back-to-back grant+accept, pointer wrap
    for (int i = 0; i < 22; i++) begin
      req_valid_i = vecs[i].rv; req_add_i = vecs[i].add; req_wen_i = vecs[i].wen;
      req_wdata_i = vecs[i].wd; gnt_i = vecs[i].gnt; vld_i = vecs[i].vld;
      rdata_i = vecs[i].rd; resp_ready_i = vecs[i].rr;
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, req_ready_o}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_req", i), {31'd0, req_o}, {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_add", i), {30'd0, add_o}, {30'd0, vecs[i].e_add});
      chk($sformatf("v%0d_wen", i), {31'd0, wen_o}, {31'd0, vecs[i].e_wen});
      chk($sformatf("v%0d_wdata", i), wdata_o, vecs[i].e_wd);
      chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid_o}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d_rdata", i), resp_rdata_o, vecs[i].e_rdata);
      chk($sformatf("v%0d_cnt", i), {29'd0, outstanding_o}, {29'd0, vecs[i].e_cnt});
      @(negedge clk_i);
    end
    vld_i = 1'b0;

    // credit exhaustion with responses held back
    resp_cnt = 32'h100;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'(i), 1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("credit_acc%0d", i), {31'd0, obs_acc}, 32'd1);
    end
    chk("credit_cnt4", {29'd0, outstanding_o}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk($sformatf("credit_no_acc%0d", i), {31'd0, obs_acc}, 32'd0);
    end
    chk("credit_cnt_hold", {29'd0, outstanding_o}, 32'd4);
    chk("credit_resp_valid", {31'd0, resp_valid_o}, 32'd1);

    // full-credit release: pop with a waiting request, accept only next cycle
    cyc(1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("release_no_acc", {31'd0, obs_acc}, 32'd0);
    chk("release_pop", {31'd0, obs_pop}, 32'd1);
    chk("release_data", obs_data, 32'h100);
    chk("release_cnt3", {29'd0, outstanding_o}, 32'd3);
    cyc(1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("release_acc", {31'd0, obs_acc}, 32'd1);
    chk("release_cnt4", {29'd0, outstanding_o}, 32'd4);
    begin
      logic [31:0] exp_d;
      exp_d = 32'h101;
      for (int k = 0; k < 20 && outstanding_o != 3'd0; k++) begin
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
        if (obs_pop) begin
          chk("drain_data", obs_data, exp_d);
          exp_d = exp_d + 32'd1;
        end
      end
      chk("drain_last", exp_d, 32'h105);
      chk("drain_cnt", {29'd0, outstanding_o}, 32'd0);
    end

    // in-order data with toggling response back-pressure
    begin
      int issued, got;
      issued = 0; got = 0; resp_cnt = 32'h0;
      for (int k = 0; k < 200 && got < 8; k++) begin
        cyc(issued < 8, 2'(k), 1'b0, 32'h0, 1'b1, k[0]);
        if (obs_acc) issued++;
        if (obs_pop) begin
          chk($sformatf("inorder_%0d", got), obs_data, 32'(got));
          got++;
        end
      end
      chk("inorder_count", 32'(got), 32'd8);
      cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("inorder_no_dup", {31'd0, obs_pop}, 32'd0);
      chk("inorder_cnt", {29'd0, outstanding_o}, 32'd0);
    end

    // asynchronous reset with 3 outstanding and the register full
    resp_cnt = 32'h200;
    cyc(1'b1, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 32'h5555AAAA, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_req", {31'd0, req_o}, 32'd1);
    chk("pre_rst_cnt", {29'd0, outstanding_o}, 32'd3);
    chk("pre_rst_rdata", resp_rdata_o, 32'h200);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_req", {31'd0, req_o}, 32'd0);
    chk("arst_add", {30'd0, add_o}, 32'd0);
    chk("arst_wen", {31'd0, wen_o}, 32'd0);
    chk("arst_wdata", wdata_o, 32'h0);
    chk("arst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
    chk("arst_rdata", resp_rdata_o, 32'h0);
    chk("arst_cnt", {29'd0, outstanding_o}, 32'd0);
    pend_vld = 1'b0; vld_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("post_rst_cnt", {29'd0, outstanding_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
